// File: rtl/heart_rate_calc.sv
// Heart-rate calculator: measures the inter-beat interval between accepted peaks and
// converts it to BPM (binary and 3 BCD digits) with a sequential divider and double-dabble.
module heart_rate_calc #(
  parameter int FS      = 100,
  parameter int CNT_W   = 12,
  parameter int MIN_INT = 30,
  parameter int MAX_INT = 300,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic       peak,
  output logic [7:0] bpm,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bpm_valid,
  output logic       no_pulse,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  // Handshake: sample_valid and peak are single-cycle strobes with no ready path.
  // busy says a peak arriving now will be dropped, and overrun flags each such drop.

  typedef enum logic [1:0] {IDLE, COUNT, DIV, BCD} state_t;

  localparam int SW = $clog2(DIV_W);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(60 * FS);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_INT);
  localparam logic [CNT_W:0]   MIN_I    = (CNT_W+1)'(MIN_INT);
  localparam logic [CNT_W:0]   MAX_I    = (CNT_W+1)'(MAX_INT);
  localparam logic [SW-1:0]    LAST_DIV = SW'(DIV_W - 1);
  localparam logic [SW-1:0]    LAST_BCD = SW'(7);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   ival;
  logic             timeout, accept;

  logic [DIV_W-1:0] quo, dsr, rem;
  logic [DIV_W:0]   rem_sh, rem_nxt;
  logic [DIV_W-1:0] quo_nxt;
  logic             ge;
  logic [SW-1:0]    step;
  logic [19:0]      dd, dd_nxt;

  // One double-dabble step: add 3 to any digit >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  assign ival      = {1'b0, cnt} + {{CNT_W{1'b0}}, sample_valid};
  assign busy      = (state == DIV) || (state == BCD);
  assign overrun   = peak && busy;
  assign dbg_state = state;

  always_comb begin
    timeout = (state == COUNT) && (cnt == MAX_C);
    accept  = (state == COUNT) && peak && !timeout && (ival >= MIN_I) && (ival < MAX_I);
    rem_sh  = {rem, quo[DIV_W-1]};
    ge      = rem_sh >= {1'b0, dsr};
    rem_nxt = ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
    quo_nxt = {quo[DIV_W-2:0], ge};
    dd_nxt  = dd_step(dd);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (peak) state_nxt = COUNT;
      COUNT: begin
        if (timeout)     state_nxt = IDLE;
        else if (accept) state_nxt = DIV;
      end
      DIV:     if (step == LAST_DIV) state_nxt = BCD;
      BCD:     if (step == LAST_BCD) state_nxt = COUNT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dsr       <= '0;
      step      <= '0;
      dd        <= '0;
      bpm       <= '0;
      bcd_hund  <= '0;
      bcd_tens  <= '0;
      bcd_ones  <= '0;
      bpm_valid <= 1'b0;
      no_pulse  <= 1'b1;
    end else begin
      bpm_valid <= 1'b0;
      // The interval keeps counting through DIV/BCD so the next beat is measured from the accepted peak.
      if (state == IDLE || accept || timeout) cnt <= '0;
      else if (sample_valid && cnt != MAX_C)  cnt <= cnt + 1'b1;
      case (state)
        COUNT: begin
          if (timeout) begin
            bpm      <= '0;
            bcd_hund <= '0;
            bcd_tens <= '0;
            bcd_ones <= '0;
            no_pulse <= 1'b1;
          end else if (accept) begin
            dsr  <= DIV_W'(ival);
            quo  <= DIVIDEND;
            rem  <= '0;
            step <= '0;
          end
        end
        DIV: begin
          quo  <= quo_nxt;
          rem  <= DIV_W'(rem_nxt);
          step <= step + 1'b1;
          if (step == LAST_DIV) begin
            dd   <= {12'b0, quo_nxt[7:0]};
            step <= '0;
          end
        end
        BCD: begin
          dd   <= dd_nxt;
          step <= step + 1'b1;
          if (step == LAST_BCD) begin
            bpm       <= quo[7:0];
            bcd_hund  <= dd_nxt[19:16];
            bcd_tens  <= dd_nxt[15:12];
            bcd_ones  <= dd_nxt[11:8];
            bpm_valid <= 1'b1;
            no_pulse  <= 1'b0;
            step      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heart_rate_calc.sv
// Bench for heart_rate_calc: directed beat scenarios plus random sample/peak traffic,
// checked every cycle against an interval/BPM model built from plain arithmetic.
module tb_heart_rate_calc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_valid = 1'b0;
  logic       peak = 1'b0;
  logic [7:0] bpm;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       bpm_valid, no_pulse, busy, overrun;
  logic [1:0] dbg_state;

  heart_rate_calc dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .peak(peak),
    .bpm(bpm), .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bpm_valid(bpm_valid), .no_pulse(no_pulse), .busy(busy), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int last_peak_cyc = -1;
  int n_valid_seen = 0;
  bit obs_ovr;

  // reference model: tracking flag, samples since accepted peak, pending result
  bit m_track, m_np, m_valid;
  int m_cnt, m_pend_at, m_pend_bpm, m_bpm;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 300) ? 300 : v;
  endfunction

  task automatic model_reset();
    m_track = 0; m_np = 1; m_valid = 0;
    m_cnt = 0; m_pend_at = -1; m_pend_bpm = 0; m_bpm = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; sample_valid = 1'b0; peak = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_bpm", bpm, 0);
    check("rst_bcd", {bcd_hund, bcd_tens, bcd_ones}, 0);
    check("rst_no_pulse", no_pulse, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", bpm_valid, 0);
    check("rst_state", dbg_state, 0);
    model_reset();
    n_valid_seen = 0;
  endtask

  // driver: one clock with given inputs, full output check, then model step
  task automatic cycle(input bit sv, input bit pk);
    bit busy_now;
    int ival;
    @(posedge clk); #1;
    sample_valid = sv; peak = pk; cyc++;
    @(negedge clk);
    busy_now = (m_pend_at > cyc);
    check("busy", busy, busy_now);
    check("overrun", overrun, pk && busy_now);
    check("bpm_valid", bpm_valid, m_valid);
    check("bpm", bpm, m_bpm);
    check("bcd_hund", bcd_hund, m_bpm / 100);
    check("bcd_tens", bcd_tens, (m_bpm / 10) % 10);
    check("bcd_ones", bcd_ones, m_bpm % 10);
    check("no_pulse", no_pulse, m_np);
    obs_ovr = overrun;
    if (bpm_valid) begin
      last_valid_cyc = cyc;
      n_valid_seen++;
    end
    m_valid = 0;
    if (!m_track) begin
      if (pk) begin m_track = 1; m_cnt = 0; end
    end else if (busy_now) begin
      m_cnt = sat(m_cnt + sv);
      if (m_pend_at == cyc + 1) begin
        m_bpm = m_pend_bpm; m_np = 0; m_valid = 1; m_pend_at = -1;
      end
    end else begin
      ival = m_cnt + sv;
      if (m_cnt == 300) begin
        m_track = 0; m_cnt = 0; m_bpm = 0; m_np = 1;
      end else if (pk && ival >= 30 && ival < 300) begin
        m_pend_at = cyc + 25; m_pend_bpm = (6000 / ival) % 256; m_cnt = 0;
        last_peak_cyc = cyc;
      end else begin
        m_cnt = sat(m_cnt + sv);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  // n samples (one every other clock), then a peak on a clock with no sample
  task automatic beat_after(input int n);
    for (int i = 0; i < n; i++) begin cycle(0, 0); cycle(1, 0); end
    cycle(0, 1);
  endtask

  task automatic expect_bpm(input string tag, input int b, input int h, input int t, input int o);
    check({tag, "_bpm"}, bpm, b);
    check({tag, "_hund"}, bcd_hund, h);
    check({tag, "_tens"}, bcd_tens, t);
    check({tag, "_ones"}, bcd_ones, o);
  endtask

  initial begin
    model_reset();
    // reset, then first peak only arms
    do_reset();
    cycle(0, 1);
    idle_cycles(30);
    check("t1_no_valid", n_valid_seen, 0);
    // 75 samples -> 80 BPM, 25-cycle latency
    beat_after(75);
    idle_cycles(30);
    check("t2_latency", last_valid_cyc - last_peak_cyc, 25);
    expect_bpm("t2", 80, 0, 8, 0);
    check("t2_no_pulse", no_pulse, 0);
    // 60 -> 100, 31 -> 193 (truncated)
    beat_after(60);
    idle_cycles(30);
    expect_bpm("t3a", 100, 1, 0, 0);
    beat_after(31);
    idle_cycles(30);
    expect_bpm("t3b", 193, 1, 9, 3);
    // glitch at 29 ignored, real beat at 75 from the accepted peak
    beat_after(29);
    idle_cycles(30);
    expect_bpm("t4_glitch", 193, 1, 9, 3);
    beat_after(46);
    idle_cycles(30);
    expect_bpm("t4", 80, 0, 8, 0);
    // timeout after 300 samples, next peak only re-arms
    for (int i = 0; i < 300; i++) begin cycle(0, 0); cycle(1, 0); end
    idle_cycles(2);
    expect_bpm("t5_timeout", 0, 0, 0, 0);
    check("t5_no_pulse", no_pulse, 1);
    cycle(0, 1);
    idle_cycles(30);
    check("t5_rearm_np", no_pulse, 1);
    beat_after(75);
    idle_cycles(30);
    expect_bpm("t5", 80, 0, 8, 0);
    // peak 5 clocks into DIV is dropped with overrun
    beat_after(60);
    idle_cycles(4);
    cycle(0, 1);
    check("t6_overrun", obs_ovr, 1);
    idle_cycles(30);
    expect_bpm("t6", 100, 1, 0, 0);
    // reset in the middle of BCD aborts the result
    beat_after(75);
    idle_cycles(20);
    do_reset();
    idle_cycles(30);
    check("t6_abort_valid", n_valid_seen, 0);
    expect_bpm("t6_abort", 0, 0, 0, 0);
    // random traffic: frequent peaks, then sparse peaks for timeouts
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
